// File: rtl/bip_phase_sequencer.sv
// Phase sequencer for a simple accumulator CPU: steps FETCH/DECODE/EXECUTE/WRITEBACK,
// issues the datapath strobes and counts retired instructions.
module bip_phase_sequencer #(
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   Clock,
   input  logic                   Reset,
   input  logic                   Start,
   input  logic [4:0]             Opcode,
   input  logic                   Stall,
   output logic                   IrLoad,
   output logic                   RdEnable,
   output logic                   WrEnable,
   output logic                   AccLoad,
   output logic                   PcEnable,
   output logic [2:0]             Phase,
   output logic                   Running,
   output logic                   Halted,
   output logic [COUNT_WIDTH-1:0] InstrCount
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] FETCH     = 3'd1;
   localparam logic [2:0] DECODE    = 3'd2;
   localparam logic [2:0] EXECUTE   = 3'd3;
   localparam logic [2:0] WRITEBACK = 3'd4;
   localparam logic [2:0] HALTED    = 3'd5;

   localparam logic [4:0] OP_HLT  = 5'b00000;
   localparam logic [4:0] OP_STO  = 5'b00001;
   localparam logic [4:0] OP_LD   = 5'b00010;
   localparam logic [4:0] OP_LDI  = 5'b00011;
   localparam logic [4:0] OP_ADD  = 5'b00100;
   localparam logic [4:0] OP_ADDI = 5'b00101;
   localparam logic [4:0] OP_SUB  = 5'b00110;
   localparam logic [4:0] OP_SUBI = 5'b00111;

   localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

   logic [2:0] state;
   logic [2:0] state_nxt;
   logic [4:0] op_q;
   logic       is_rd;
   logic       is_sto;
   logic       is_imm;

   // Opcode classes come from the latched opcode only, so no input reaches an output.
   assign is_rd  = (op_q == OP_LD) || (op_q == OP_ADD) || (op_q == OP_SUB);
   assign is_sto = (op_q == OP_STO);
   assign is_imm = (op_q == OP_LDI) || (op_q == OP_ADDI) || (op_q == OP_SUBI);

   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE:      state_nxt = Start ? FETCH : IDLE;
         FETCH:     state_nxt = DECODE;
         DECODE:    state_nxt = (Opcode == OP_HLT) ? HALTED : EXECUTE;
         EXECUTE:   state_nxt = (Stall && (is_rd || is_sto)) ? EXECUTE : WRITEBACK;
         WRITEBACK: state_nxt = FETCH;
         HALTED:    state_nxt = HALTED;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state      <= IDLE;
         op_q       <= OP_HLT;
         InstrCount <= '0;
      end else begin
         state <= state_nxt;
         if (state == DECODE) begin
            op_q <= Opcode;
         end
         if (state == WRITEBACK) begin
            InstrCount <= InstrCount + COUNT_ONE;
         end
      end
   end

   // Strobes are level outputs of the current phase; the datapath samples them
   // on the next rising edge, and a stalled memory access simply holds its enable.
   assign IrLoad   = (state == FETCH);
   assign RdEnable = (state == EXECUTE) && is_rd;
   assign WrEnable = (state == EXECUTE) && is_sto;
   assign AccLoad  = (state == WRITEBACK) && (is_rd || is_imm);
   assign PcEnable = (state == WRITEBACK);
   assign Phase    = state;
   assign Running  = (state == FETCH) || (state == DECODE) ||
                     (state == EXECUTE) || (state == WRITEBACK);
   assign Halted   = (state == HALTED);

endmodule

// File: tb/tb_bip_phase_sequencer.sv
// Directed bench for bip_phase_sequencer: per-cycle expected output words are queued
// by the driver and compared by an independent negedge monitor.
module tb_bip_phase_sequencer;

   localparam int CW = 4;
   localparam int W  = 10 + CW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [4:0]    opcode = 5'b0;
   logic          stall = 1'b0;
   logic          irload, rden, wren, accload, pcen, running, halted;
   logic [2:0]    phase;
   logic [CW-1:0] count;

   logic [W-1:0]  exp_q[$];
   int            total_cnt = 0;
   int            pass_cnt  = 0;

   bip_phase_sequencer #(.COUNT_WIDTH(CW)) dut (
      .Clock(clk), .Reset(rst), .Start(start), .Opcode(opcode), .Stall(stall),
      .IrLoad(irload), .RdEnable(rden), .WrEnable(wren), .AccLoad(accload),
      .PcEnable(pcen), .Phase(phase), .Running(running), .Halted(halted),
      .InstrCount(count)
   );

   always #5 clk = ~clk;

   // Expected word layout: {ir, rd, wr, acc, pc, phase, running, halted, count}
   function automatic logic [W-1:0] ex(input logic ir, input logic rd, input logic wr,
                                       input logic acc, input logic pc,
                                       input logic [2:0] ph, input logic run,
                                       input logic hlt, input logic [CW-1:0] c);
      return {ir, rd, wr, acc, pc, ph, run, hlt, c};
   endfunction

   function automatic logic [W-1:0] idle_w(input logic [CW-1:0] c);
      return ex(0, 0, 0, 0, 0, 3'd0, 0, 0, c);
   endfunction
   function automatic logic [W-1:0] fetch_w(input logic [CW-1:0] c);
      return ex(1, 0, 0, 0, 0, 3'd1, 1, 0, c);
   endfunction
   function automatic logic [W-1:0] dec_w(input logic [CW-1:0] c);
      return ex(0, 0, 0, 0, 0, 3'd2, 1, 0, c);
   endfunction
   function automatic logic [W-1:0] exe_w(input logic rd, input logic wr, input logic [CW-1:0] c);
      return ex(0, rd, wr, 0, 0, 3'd3, 1, 0, c);
   endfunction
   function automatic logic [W-1:0] wb_w(input logic acc, input logic [CW-1:0] c);
      return ex(0, 0, 0, acc, 1, 3'd4, 1, 0, c);
   endfunction
   function automatic logic [W-1:0] halt_w(input logic [CW-1:0] c);
      return ex(0, 0, 0, 0, 0, 3'd5, 0, 1, c);
   endfunction

   // One cycle: drive inputs just after the rising edge, queue what this cycle must show.
   task automatic step(input logic r, input logic s, input logic [4:0] op,
                       input logic st, input logic [W-1:0] e);
      rst    = r;
      start  = s;
      opcode = op;
      stall  = st;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      logic [W-1:0] got;
      logic [W-1:0] want;
      got = {irload, rden, wren, accload, pcen, phase, running, halted, count};
      if (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         total_cnt++;
         if (got !== want) begin
            $display("FAIL outputs t=%0t got=%b want=%b (ir rd wr acc pc ph3 run hlt cnt)",
                     $time, got, want);
         end else begin
            pass_cnt++;
         end
      end
      total_cnt++;
      if ((32'(irload) + 32'(rden | wren) + 32'(pcen)) > 1 || (rden && wren)) begin
         $display("FAIL strobe_exclusive t=%0t ir=%b rd=%b wr=%b pc=%b",
                  $time, irload, rden, wren, pcen);
      end else begin
         pass_cnt++;
      end
   end

   initial begin
      @(posedge clk);
      #1;
      step(1, 0, 5'b00000, 0, idle_w(0));
      step(1, 1, 5'b00000, 0, idle_w(0));

      // LDI with Stall high during EXECUTE: ignored, one-cycle EXECUTE
      step(0, 1, 5'b00000, 0, idle_w(0));
      step(0, 0, 5'b00000, 0, fetch_w(0));
      step(0, 0, 5'b00011, 0, dec_w(0));
      step(0, 0, 5'b00000, 1, exe_w(0, 0, 0));
      step(0, 0, 5'b00000, 0, wb_w(1, 0));

      // STO stalled 3 cycles: WrEnable held 4 cycles, no AccLoad
      step(0, 0, 5'b00000, 0, fetch_w(1));
      step(0, 0, 5'b00001, 0, dec_w(1));
      step(0, 0, 5'b00000, 1, exe_w(0, 1, 1));
      step(0, 0, 5'b00000, 1, exe_w(0, 1, 1));
      step(0, 0, 5'b00000, 1, exe_w(0, 1, 1));
      step(0, 0, 5'b00000, 0, exe_w(0, 1, 1));
      step(0, 0, 5'b00000, 0, wb_w(0, 1));

      // Unassigned opcode 11111 behaves as NOP
      step(0, 0, 5'b00000, 0, fetch_w(2));
      step(0, 0, 5'b11111, 0, dec_w(2));
      step(0, 0, 5'b00000, 1, exe_w(0, 0, 2));
      step(0, 0, 5'b00000, 0, wb_w(0, 2));
      step(0, 1, 5'b00000, 0, fetch_w(3));

      // 16 ADDI from a fresh reset: counter wraps 15 -> 0
      step(1, 0, 5'b00000, 0, idle_w(0));
      step(0, 1, 5'b00000, 0, idle_w(0));
      for (int i = 0; i < 16; i++) begin
         step(0, 0, 5'b00000, 0, fetch_w(CW'(i)));
         step(0, 0, 5'b00101, 0, dec_w(CW'(i)));
         step(0, 0, 5'b00000, 1, exe_w(0, 0, CW'(i)));
         step(0, 0, 5'b00000, 0, wb_w(1, CW'(i)));
      end

      // HLT: terminal, Start ignored, count frozen
      step(0, 0, 5'b00000, 0, fetch_w(0));
      step(0, 0, 5'b00000, 0, dec_w(0));
      step(0, 1, 5'b00000, 0, halt_w(0));
      step(0, 0, 5'b00000, 0, halt_w(0));
      step(0, 1, 5'b00011, 0, halt_w(0));
      step(0, 1, 5'b00000, 0, halt_w(0));

      // Reset during a stalled LD: outputs drop before the next edge
      step(1, 0, 5'b00000, 0, idle_w(0));
      step(0, 1, 5'b00000, 0, idle_w(0));
      step(0, 0, 5'b00000, 0, fetch_w(0));
      step(0, 0, 5'b00010, 0, dec_w(0));
      step(0, 0, 5'b00000, 1, exe_w(1, 0, 0));
      step(0, 0, 5'b00000, 1, exe_w(1, 0, 0));
      step(1, 0, 5'b00000, 1, idle_w(0));
      step(0, 0, 5'b00000, 0, idle_w(0));
      step(0, 0, 5'b00000, 1, idle_w(0));
      step(0, 0, 5'b00000, 0, idle_w(0));

      repeat (4) @(negedge clk);
      if (exp_q.size() != 0) begin
         total_cnt++;
         $display("FAIL drain queue_left=%0d required=0", exp_q.size());
      end
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/bip_phase_sequencer.md
BIP_PHASE_SEQUENCER -- requirements
Module: bip_phase_sequencer

Interface
REQ-001 The block SHALL have parameter COUNT_WIDTH, default 16, giving the width of the retired-instruction counter.
REQ-002 The block SHALL have port Clock, input, 1 bit: the single system clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port Start, input, 1 bit: a request to begin execution, sampled only in IDLE.
REQ-005 The block SHALL have port Opcode, input, 5 bits: the opcode field of the instruction register, sampled only in DECODE.
REQ-006 The block SHALL have port Stall, input, 1 bit: data memory not ready, honoured only in EXECUTE for memory opcodes.
REQ-007 The block SHALL have port IrLoad, output, 1 bit: load strobe for the instruction register.
REQ-008 The block SHALL have port RdEnable, output, 1 bit: data-memory read enable.
REQ-009 The block SHALL have port WrEnable, output, 1 bit: data-memory write enable.
REQ-010 The block SHALL have port AccLoad, output, 1 bit: accumulator load strobe.
REQ-011 The block SHALL have port PcEnable, output, 1 bit: program-counter advance strobe.
REQ-012 The block SHALL have port Phase, output, 3 bits: the current state encoding.
REQ-013 The block SHALL have port Running, output, 1 bit: high in FETCH, DECODE, EXECUTE and WRITEBACK.
REQ-014 The block SHALL have port Halted, output, 1 bit: high only in HALTED.
REQ-015 The block SHALL have port InstrCount, output, COUNT_WIDTH bits: count of retired instructions.

Function
REQ-016 The FSM SHALL use these states and encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALTED=5; encodings 6 and 7 SHALL go to IDLE on the next edge.
REQ-017 All outputs SHALL be decoded from the state register and the latched opcode only, with no combinational path from Start, Opcode or Stall to any output.
REQ-018 IDLE SHALL move to FETCH when Start=1; otherwise it SHALL remain in IDLE.
REQ-019 FETCH SHALL assert IrLoad for exactly one cycle and then move unconditionally to DECODE.
REQ-020 DECODE SHALL latch Opcode into an internal register; if the opcode is HLT (00000) it SHALL move to HALTED, otherwise to EXECUTE.
REQ-021 Opcode classes SHALL be: STO=00001; memory reads LD=00010, ADD=00100, SUB=00110; immediates LDI=00011, ADDI=00101, SUBI=00111; every other opcode SHALL be treated as a NOP.
REQ-022 In EXECUTE, RdEnable SHALL be asserted for memory-read opcodes and WrEnable for STO; both SHALL be 0 for immediate and NOP opcodes.
REQ-023 In EXECUTE with Stall=1 and a memory opcode (STO or a memory read), the FSM SHALL hold in EXECUTE with its enable kept asserted; otherwise it SHALL move to WRITEBACK.
REQ-024 Stall SHALL be ignored for immediate and NOP opcodes, giving an EXECUTE of exactly one cycle.
REQ-025 WRITEBACK SHALL assert PcEnable for one cycle for every opcode, and AccLoad for memory-read and immediate opcodes only; it SHALL then move to FETCH.
REQ-026 InstrCount SHALL increment by 1 on each WRITEBACK cycle, modulo 2^COUNT_WIDTH (it wraps to 0 after all-ones); HLT SHALL not be counted.
REQ-027 HALTED SHALL be terminal: Start is ignored, PcEnable is never asserted, and only Reset exits it.
REQ-028 The unstalled instruction latency from FETCH to the next FETCH SHALL be 4 cycles; each stall cycle SHALL add exactly 1 cycle.
REQ-029 At most one of IrLoad, RdEnable/WrEnable and PcEnable SHALL be high in any cycle, and RdEnable and WrEnable SHALL never be high together.

Reset
REQ-030 Reset=1 SHALL immediately, without waiting for a clock edge, force state IDLE, latched opcode 00000, InstrCount 0, and all strobes, Running and Halted to 0.
REQ-031 Reset asserted in the middle of an instruction, including during a stalled STO, SHALL drop WrEnable and RdEnable in the same cycle, with no pending write completing.
REQ-032 After Reset is released, the FSM SHALL remain in IDLE until Start=1 is sampled.

Verification
REQ-033 Bench scenario: Reset, Start pulse, Opcode=LDI (00011) → IrLoad at cycle 1, EXECUTE with no enables, AccLoad+PcEnable at cycle 4, InstrCount=1.
REQ-034 Bench scenario: Opcode=STO with Stall=1 for 3 cycles → WrEnable high 4 cycles, PcEnable at cycle 7, AccLoad=0.
REQ-035 Bench scenario: Opcode=HLT → Halted=1 from cycle 3, PcEnable never set, InstrCount unchanged, Start pulses ignored.
REQ-036 Bench scenario: COUNT_WIDTH=4, run 16 ADDI instructions → InstrCount wraps from 15 to 0.
REQ-037 Bench scenario: Reset asserted mid-EXECUTE of LD with Stall=1 → RdEnable=0 and Phase=0 before the next edge.
REQ-038 Bench scenario: Opcode=11111 → treated as NOP: no RdEnable/WrEnable/AccLoad, PcEnable=1, InstrCount increments.
